pipe_adder_flags: RTL and testbench

Parametrised, pipelined add/subtract unit with N/Z/C/V flag generation and a valid/ready handshake on both sides. It is the successor to the single-cycle 32-bit flag adder. The carry chain is split into `STAGES` registered chunks so the ALU datapath can close timing at wider `WIDTH`. It adds subtract, add-with-carry and (optionally) signed-saturating modes, back-pressure and flush.

---
 rtl/pipe_adder_flags.sv | 180 ++++++++++++++++++
 tb/tb_pipe_adder_flags.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder_flags.sv
// Pipelined add/sub/adc unit with N/Z/C/V flags and valid/ready handshake.
// Define PIPE_ADDER_SAT_EN to build signed-saturating add for op 2'b11.
module pipe_adder_flags #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V
);

  localparam int unsigned CW   = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ADC  = 2'b10,
    OP_SADD = 2'b11
  } op_e;

  // Per-stage state: operands, partial sum, chunk carry and zero accumulator.
  logic             vld_q  [STAGES];
  logic [WIDTH-1:0] a_q    [STAGES];
  logic [WIDTH-1:0] b_q    [STAGES];
  logic [WIDTH-1:0] s_q    [STAGES];
  logic             cy_q   [STAGES];
  logic             zacc_q [STAGES];

  logic             vld_d  [STAGES];
  logic [WIDTH-1:0] a_d    [STAGES];
  logic [WIDTH-1:0] b_d    [STAGES];
  logic [WIDTH-1:0] s_d    [STAGES];
  logic             cy_d   [STAGES];
  logic             zacc_d [STAGES];

`ifdef PIPE_ADDER_SAT_EN
  op_e              op_q   [STAGES];
  op_e              op_d   [STAGES];
`endif

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [CW:0]      csum;
  logic [WIDTH-1:0] fin_sum;
  logic             fin_n, fin_z, fin_v, a_msb, b_msb;
  logic             stall;

  logic [WIDTH-1:0] sum_q;
  logic             n_q, z_q, c_q, v_q;

  function automatic logic [CW:0] add_chunk(input logic [CW-1:0] x,
                                            input logic [CW-1:0] y,
                                            input logic          ci);
    return {1'b0, x} + {1'b0, y} + {{CW{1'b0}}, ci};
  endfunction

  assign stall     = vld_q[LAST] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = vld_q[LAST];
  assign sum       = sum_q;
  assign N         = n_q;
  assign Z         = z_q;
  assign C         = c_q;
  assign V         = v_q;

  always_comb begin
    b_eff   = b;
    cin_eff = 1'b0;
    case (op_e'(op))
      OP_SUB: begin
        b_eff   = ~b;
        cin_eff = 1'b1;
      end
      OP_ADC:  cin_eff = cin;
      default: ;
    endcase
  end

  // Stage 0 consumes the live inputs; stage k consumes register k-1.
  always_comb begin
    csum       = add_chunk(a[0 +: CW], b_eff[0 +: CW], cin_eff);
    vld_d[0]   = in_valid;
    a_d[0]     = a;
    b_d[0]     = b_eff;
    s_d[0]     = '0;
    s_d[0][0 +: CW] = csum[CW-1:0];
    cy_d[0]    = csum[CW];
    zacc_d[0]  = (csum[CW-1:0] == '0);
`ifdef PIPE_ADDER_SAT_EN
    op_d[0]    = op_e'(op);
`endif
    for (int unsigned k = 1; k < STAGES; k++) begin
      csum      = add_chunk(a_q[k-1][k*CW +: CW], b_q[k-1][k*CW +: CW], cy_q[k-1]);
      vld_d[k]  = vld_q[k-1];
      a_d[k]    = a_q[k-1];
      b_d[k]    = b_q[k-1];
      s_d[k]    = s_q[k-1];
      s_d[k][k*CW +: CW] = csum[CW-1:0];
      cy_d[k]   = csum[CW];
      zacc_d[k] = zacc_q[k-1] & (csum[CW-1:0] == '0);
`ifdef PIPE_ADDER_SAT_EN
      op_d[k]   = op_q[k-1];
`endif
    end
  end

  always_comb begin
    a_msb   = a_d[LAST][WIDTH-1];
    b_msb   = b_d[LAST][WIDTH-1];
    fin_v   = (a_msb == b_msb) && (s_d[LAST][WIDTH-1] != a_msb);
    fin_sum = s_d[LAST];
    fin_z   = zacc_d[LAST];
`ifdef PIPE_ADDER_SAT_EN
    // Saturated values are never zero, so Z is forced low alongside.
    if (op_d[LAST] == OP_SADD && fin_v) begin
      fin_sum = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      fin_z   = 1'b0;
    end
`endif
    fin_n = fin_sum[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        vld_q[k]  <= 1'b0;
        a_q[k]    <= '0;
        b_q[k]    <= '0;
        s_q[k]    <= '0;
        cy_q[k]   <= 1'b0;
        zacc_q[k] <= 1'b0;
`ifdef PIPE_ADDER_SAT_EN
        op_q[k]   <= OP_ADD;
`endif
      end
      sum_q <= '0;
      n_q   <= 1'b0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
    end else begin
      if (!stall) begin
        for (int unsigned k = 0; k < STAGES; k++) begin
          a_q[k]    <= a_d[k];
          b_q[k]    <= b_d[k];
          s_q[k]    <= s_d[k];
          cy_q[k]   <= cy_d[k];
          zacc_q[k] <= zacc_d[k];
`ifdef PIPE_ADDER_SAT_EN
          op_q[k]   <= op_d[k];
`endif
        end
        sum_q <= fin_sum;
        n_q   <= fin_n;
        z_q   <= fin_z;
        c_q   <= cy_d[LAST];
        v_q   <= fin_v;
      end
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (flush)       vld_q[k] <= 1'b0;
        else if (!stall) vld_q[k] <= vld_d[k];
      end
    end
  end

endmodule

// File: tb/tb_pipe_adder_flags.sv
// Self-checking bench for pipe_adder_flags against an arithmetic reference model.
module tb_pipe_adder_flags;
  localparam int unsigned W = 32;
  localparam int unsigned S = 4;

  logic         clk = 1'b0;
  logic         rst_n, flush, in_valid, in_ready, out_valid, out_ready, cin;
  logic [W-1:0] a, b, sum;
  logic [1:0]   op;
  logic         N, Z, C, V;

  typedef struct packed {
    logic [W-1:0] sum;
    logic n, z, c, v;
  } res_t;

  res_t expq[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pipe_adder_flags #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .N(N), .Z(Z), .C(C), .V(V)
  );

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic [1:0] o, input logic ci);
    res_t   r;
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint s;
    longint maxs = 64'sd2147483647;
    longint mins = -64'sd2147483648;
    logic [W:0] u;
    case (o)
      2'b01: begin
        u    = {1'b0, x - y};
        u[W] = (x >= y);
        s    = sx - sy;
      end
      2'b10: begin
        u = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        s = sx + sy + longint'(ci);
      end
      default: begin
        u = {1'b0, x} + {1'b0, y};
        s = sx + sy;
      end
    endcase
    r.sum = u[W-1:0];
    r.c   = u[W];
    r.v   = (s > maxs) || (s < mins);
`ifdef PIPE_ADDER_SAT_EN
    if (o == 2'b11 && r.v) r.sum = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    r.n = r.sum[W-1];
    r.z = (r.sum == '0);
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = 2'b00; cin = 1'b0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    checks++; if (sum !== '0) begin errors++; $display("FAIL reset_sum: got %h exp 0", sum); end
    checks++; if ({N, Z, C, V} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b exp 0000", {N, Z, C, V}); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_ops();
    logic [W-1:0] ta [5] = '{32'h7FFF_FFFF, 32'd5, 32'd3, 32'hFFFF_FFFF, 32'h7FFF_FFF0};
    logic [W-1:0] tb [5] = '{32'h0000_0001, 32'd5, 32'd5, 32'h0000_0000, 32'h0000_0020};
    logic [1:0]   to [5] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
    logic         tc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    res_t         r;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = ta[i]; b = tb[i]; op = to[i]; cin = tc[i]; in_valid = 1'b1; out_ready = 1'b1;
      r = model(ta[i], tb[i], to[i], tc[i]);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ops%0d_in_ready: got %b exp 1", i, in_ready); end
      for (int j = 1; j <= int'(S); j++) begin
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        if (j < int'(S)) begin
          checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ops%0d_early_valid: cycle %0d got %b exp 0", i, j, out_valid); end
        end else begin
          checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ops%0d_latency: got out_valid=%b exp 1", i, out_valid); end
          checks++;
          if ({sum, N, Z, C, V} !== r) begin
            errors++;
            $display("FAIL ops%0d_result: got sum=%h nzcv=%b%b%b%b exp sum=%h nzcv=%b%b%b%b",
                     i, sum, N, Z, C, V, r.sum, r.n, r.z, r.c, r.v);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    res_t r;
    expq.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3)); cin = 1'($urandom_range(0, 1));
      in_valid  = (cyc < 360) && ($urandom_range(0, 9) < 7);
      out_ready = (cyc >= 360) || ($urandom_range(0, 9) < 7);
      #1;
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        errors++; $display("FAIL rand_in_ready: cycle %0d got %b out_valid=%b out_ready=%b", cyc, in_ready, out_valid, out_ready);
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL rand_spurious: cycle %0d got out_valid=1 exp no pending result", cyc);
        end else if ({sum, N, Z, C, V} !== expq[0]) begin
          errors++;
          $display("FAIL rand_result: cycle %0d got sum=%h nzcv=%b%b%b%b exp sum=%h nzcv=%b%b%b%b",
                   cyc, sum, N, Z, C, V, expq[0].sum, expq[0].n, expq[0].z, expq[0].c, expq[0].v);
        end
        if (out_ready && expq.size() != 0) void'(expq.pop_front());
      end
      if (in_valid && in_ready) begin
        r = model(a, b, op, cin);
        expq.push_back(r);
      end
    end
    checks++; if (expq.size() != 0) begin errors++; $display("FAIL rand_drain: got %0d undelivered exp 0", expq.size()); end
  endtask

  task automatic test_back_to_back();
    int sent = 0, got = 0, stall_left = 0;
    bit seen_first = 0;
    expq.delete();
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; op = 2'b00; cin = 1'b0;
      in_valid  = (sent < 6);
      out_ready = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_in_ready: got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_stall_valid: got %b exp 1", out_valid); end
        stall_left--;
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL b2b_spurious: cycle %0d got out_valid=1 exp none", cyc);
        end else if ({sum, N, Z, C, V} !== expq[0]) begin
          errors++;
          $display("FAIL b2b_result: cycle %0d got sum=%h nzcv=%b%b%b%b exp sum=%h nzcv=%b%b%b%b",
                   cyc, sum, N, Z, C, V, expq[0].sum, expq[0].n, expq[0].z, expq[0].c, expq[0].v);
        end
        if (out_ready && expq.size() != 0) begin
          void'(expq.pop_front());
          got++;
          if (!seen_first) begin seen_first = 1; stall_left = 3; end
        end
      end
      if (in_valid && in_ready) begin
        expq.push_back(model(a, b, op, cin));
        sent++;
      end
    end
    checks++; if (got != 6) begin errors++; $display("FAIL b2b_count: got %0d exp 6", got); end
    checks++; if (expq.size() != 0) begin errors++; $display("FAIL b2b_leftover: got %0d exp 0", expq.size()); end
  endtask

  task automatic test_flush();
    res_t r;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 32'h100 + i; b = 32'h1; op = 2'b00; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    end
    @(negedge clk); flush = 1'b1; a = 32'hDEAD; in_valid = 1'b1;
    @(negedge clk); flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_quiet: cycle %0d got out_valid=%b exp 0", i, out_valid); end
      @(negedge clk);
    end
    a = 32'h0000_0042; b = 32'hFFFF_FFFF; op = 2'b01; in_valid = 1'b1;
    r = model(a, b, op, cin);
    for (int j = 1; j <= int'(S); j++) begin
      @(negedge clk); in_valid = 1'b0; #1;
      if (j < int'(S)) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_early_valid: cycle %0d got %b exp 0", j, out_valid); end
      end else begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_after_latency: got out_valid=%b exp 1", out_valid); end
        checks++; if ({sum, N, Z, C, V} !== r) begin errors++; $display("FAIL flush_after_result: got sum=%h exp sum=%h", sum, r.sum); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    res_t r;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 32'h1234 + i; b = 32'h10; op = 2'b00; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    end
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); #1;
    r = model(32'h1234, 32'h10, 2'b00, 1'b0);
    checks++; if (out_valid !== 1'b1 || sum !== r.sum) begin errors++; $display("FAIL rstmid_pre: got valid=%b sum=%h exp valid=1 sum=%h", out_valid, sum, r.sum); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b exp 0", out_valid); end
    checks++; if (sum !== '0) begin errors++; $display("FAIL rstmid_sum: got %h exp 0", sum); end
    checks++; if ({N, Z, C, V} !== 4'b0000) begin errors++; $display("FAIL rstmid_flags: got %b exp 0000", {N, Z, C, V}); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    a = 32'h8000_0000; b = 32'h8000_0000; op = 2'b00; in_valid = 1'b1;
    r = model(a, b, op, cin);
    for (int j = 1; j <= int'(S); j++) begin
      @(negedge clk); in_valid = 1'b0; #1;
      if (j < int'(S)) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_early_valid: cycle %0d got %b exp 0", j, out_valid); end
      end else begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_latency: got out_valid=%b exp 1", out_valid); end
        checks++;
        if ({sum, N, Z, C, V} !== r) begin
          errors++; $display("FAIL rstmid_result: got sum=%h nzcv=%b%b%b%b exp sum=%h nzcv=%b%b%b%b",
                             sum, N, Z, C, V, r.sum, r.n, r.z, r.c, r.v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_back_to_back();
    test_random();
    test_flush();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
